// File: rtl/apb2spi_master_pkg.sv
// apb2spi_master_pkg: FSM encoding and SPI frame sizing shared by the APB-to-SPI master
package apb2spi_master_pkg;
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_DONE, S_GAP} state_t;

    // R/W bit + address + payload, plus one extra byte of turnaround on reads
    function automatic int frame_bits(input int aw, input int dw, input logic wr);
        return wr ? 1 + aw + dw : 1 + aw + 2 * dw;
    endfunction
endpackage

// File: rtl/apb2spi_master_clk_gen.sv
// apb2spi_master_clk_gen: SCK divider, idle low, with single-cycle rise/fall strobes
module apb2spi_master_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_sclk,
    output logic o_rise_stb,
    output logic o_fall_stb
);
    localparam int CW = $clog2(CLK_DIV + 1);
    logic [CW-1:0] r_cnt;
    logic          w_tick;
    assign w_tick     = i_en && r_cnt == CW'(CLK_DIV - 1);
    assign o_rise_stb = w_tick && !o_sclk;
    assign o_fall_stb = w_tick && o_sclk;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            o_sclk <= 1'b0;
        end else if (!i_en) begin
            r_cnt  <= '0;
            o_sclk <= 1'b0;
        end else if (w_tick) begin
            r_cnt  <= '0;
            o_sclk <= !o_sclk;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/apb2spi_master.sv
// apb2spi_master: APB slave that turns each access into one SPI frame, wait-stating
// the host with pready low until the frame (and any read-back byte) completes.
module apb2spi_master
    import apb2spi_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4,
    parameter int SS_GAP     = 2
) (
    input  logic                  pclk,
    input  logic                  reset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  sclk,
    output logic                  ss,
    output logic                  mosi,
    input  logic                  miso
);
    localparam int SR_W = frame_bits(ADDR_WIDTH, DATA_WIDTH, 1'b0);
    localparam int WR_N = frame_bits(ADDR_WIDTH, DATA_WIDTH, 1'b1);
    localparam int BW   = $clog2(SR_W + 1);
    localparam int TW   = $clog2((CLK_DIV > SS_GAP ? CLK_DIV : SS_GAP) + 1);

    state_t                r_state;
    logic [SR_W-1:0]       r_tx;
    logic [DATA_WIDTH-1:0] r_rx;
    logic [BW-1:0]         r_bits;
    logic [TW-1:0]         r_cnt;
    logic                  r_rd;
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_div_end;
    logic                  w_gap_end;

    assign w_div_end = r_cnt == TW'(CLK_DIV - 1);
    assign w_gap_end = r_cnt == TW'(SS_GAP - 1);

    apb2spi_master_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk        (pclk),
        .rst        (reset),
        .i_en       (r_state == S_SHIFT),
        .o_sclk     (sclk),
        .o_rise_stb (w_rise),
        .o_fall_stb (w_fall)
    );

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_tx    <= '0;
            r_rx    <= '0;
            r_bits  <= '0;
            r_cnt   <= '0;
            r_rd    <= 1'b0;
            prdata  <= '0;
            pready  <= 1'b0;
            ss      <= 1'b1;
            mosi    <= 1'b0;
        end else begin
            pready <= 1'b0;
            case (r_state)
                S_IDLE: if (psel && penable && !pready) begin
                    r_state <= S_SETUP;
                    r_rd    <= !pwrite;
                    r_tx    <= {pwrite, paddr, pwdata & {DATA_WIDTH{pwrite}}, {DATA_WIDTH{1'b0}}};
                    r_bits  <= pwrite ? BW'(WR_N) : BW'(SR_W);
                    r_cnt   <= '0;
                    ss      <= 1'b0;
                    mosi    <= pwrite;
                end
                S_SETUP: if (w_div_end) begin
                    r_state <= S_SHIFT;
                    r_cnt   <= '0;
                end else begin
                    r_cnt   <= r_cnt + 1'b1;
                end
                S_SHIFT: begin
                    if (w_rise) begin
                        r_rx   <= {r_rx[DATA_WIDTH-2:0], miso};
                        r_bits <= r_bits - 1'b1;
                    end
                    // r_bits hits zero on the last rise, so this fall closes the frame
                    if (w_fall) begin
                        r_tx <= r_tx << 1;
                        mosi <= r_bits == '0 ? 1'b0 : r_tx[SR_W-2];
                        if (r_bits == '0) r_state <= S_HOLD;
                    end
                end
                S_HOLD: if (w_div_end) begin
                    r_state <= S_DONE;
                    r_cnt   <= '0;
                    ss      <= 1'b1;
                end else begin
                    r_cnt   <= r_cnt + 1'b1;
                end
                S_DONE: begin
                    r_state <= S_GAP;
                    pready  <= 1'b1;
                    if (r_rd) prdata <= r_rx;
                end
                S_GAP: if (w_gap_end) begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end else begin
                    r_cnt   <= r_cnt + 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb2spi_master.sv
// tb_apb2spi_master: two masters (CLK_DIV=4/SS_GAP=2 and CLK_DIV=1/SS_GAP=1) against an SPI slave model
module tb_apb2spi_master;
    logic       pclk = 1'b0;
    logic       reset;
    logic [1:0] psel = '0, penable = '0, pwrite = '0;
    logic [1:0] miso = '0;
    logic [6:0] paddr [2];
    logic [7:0] pwdata [2];
    wire  [7:0] prdata [2];
    wire  [1:0] pready, sclk, ss, mosi;

    always #5 pclk = ~pclk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        apb2spi_master #(.CLK_DIV(g == 0 ? 4 : 1), .SS_GAP(g == 0 ? 2 : 1)) u_dut (
            .pclk    (pclk),
            .reset   (reset),
            .psel    (psel[g]),
            .penable (penable[g]),
            .pwrite  (pwrite[g]),
            .paddr   (paddr[g]),
            .pwdata  (pwdata[g]),
            .prdata  (prdata[g]),
            .pready  (pready[g]),
            .sclk    (sclk[g]),
            .ss      (ss[g]),
            .mosi    (mosi[g]),
            .miso    (miso[g])
        );
    end

    function automatic int cd(input int g);
        return g == 0 ? 4 : 1;
    endfunction
    function automatic int sg(input int g);
        return g == 0 ? 2 : 1;
    endfunction

    // SPI slave model: counts rises, captures mosi, returns rd_byte after 16 command bits
    int          cyc = 0;
    int          nrise [2] = '{0, 0};
    int          t_fall [2] = '{0, 0};
    int          t_rise [2] = '{0, 0};
    int          gap [2] = '{1000, 1000};
    int          bad [2] = '{0, 0};
    logic [31:0] cap [2] = '{0, 0};
    logic [7:0]  rd_byte [2] = '{0, 0};
    logic [1:0]  psclk = '0, pss = 2'b11, pmosi = '0;

    always @(posedge pclk) cyc <= cyc + 1;

    always @(negedge pclk) begin
        for (int i = 0; i < 2; i++) begin
            if (pss[i] && ss[i] === 1'b0) begin
                nrise[i]  <= 0;
                cap[i]    <= '0;
                miso[i]   <= 1'b0;
                gap[i]    <= cyc - t_rise[i];
                t_fall[i] <= cyc;
            end
            if (!pss[i] && ss[i] === 1'b1) t_rise[i] <= cyc;
            if (!psclk[i] && sclk[i] === 1'b1) begin
                if (ss[i] !== 1'b0) bad[i] <= bad[i] + 1;
                cap[i]   <= {cap[i][30:0], mosi[i]};
                nrise[i] <= nrise[i] + 1;
            end
            if (psclk[i] && sclk[i] === 1'b0)
                miso[i] <= (nrise[i] >= 16 && nrise[i] < 24) ? rd_byte[i][23 - nrise[i]] : 1'b0;
            if (mosi[i] !== pmosi[i] && sclk[i] !== 1'b0) bad[i] <= bad[i] + 1;
            psclk[i] <= sclk[i];
            pss[i]   <= ss[i];
            pmosi[i] <= mosi[i];
        end
    end

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic xfer(input int g, input bit wr, input logic [6:0] a, input logic [7:0] d,
                        input logic [7:0] mb, input int lat, input logic [7:0] prd, input bit b2b,
                        input string tag);
        int n;
        rd_byte[g] = mb;
        psel[g] = 1'b1; penable[g] = 1'b0; pwrite[g] = wr; paddr[g] = a; pwdata[g] = d;
        @(negedge pclk);
        penable[g] = 1'b1;
        n = 0;
        while (pready[g] !== 1'b1 && n < 3000) begin
            @(negedge pclk);
            n++;
            if (ss[g] === 1'b0) begin
                paddr[g]  = ~a;
                pwdata[g] = ~d;
            end
        end
        if (pready[g] !== 1'b1) begin
            chk({tag, " timeout"}, 0, 1);
            psel[g] = 1'b0; penable[g] = 1'b0;
            return;
        end
        chk({tag, " latency"}, cyc - t_fall[g], lat);
        chk({tag, " rises"}, nrise[g], wr ? 16 : 24);
        chk({tag, " mosi"}, cap[g], wr ? {16'h0, 1'b1, a, d} : {8'h0, 1'b0, a, 16'h0});
        chk({tag, " prdata"}, prdata[g], prd);
        chk({tag, " ss_gap_ok"}, gap[g] >= sg(g), 1);
        chk({tag, " spi_protocol_errs"}, bad[g], 0);
        psel[g] = 1'b0; penable[g] = 1'b0;
        if (!b2b) begin
            @(negedge pclk);
            chk({tag, " pready_pulse"}, pready[g], 0);
        end
    endtask

    typedef struct {
        int         g;
        bit         wr;
        logic [6:0] a;
        logic [7:0] d;
        logic [7:0] mb;
        int         lat;
        logic [7:0] prd;
        bit         b2b;
    } vec_t;

    vec_t       tbl [5];
    logic [7:0] exp_prd [2];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{0, 1'b1, 7'h05, 8'hA5, 8'h00, 137, 8'h00, 1'b1};
        tbl[1] = '{0, 1'b0, 7'h0A, 8'h00, 8'h3C, 201, 8'h3C, 1'b0};
        tbl[2] = '{0, 1'b1, 7'h7F, 8'hFF, 8'h00, 137, 8'h3C, 1'b0};
        tbl[3] = '{1, 1'b0, 7'h33, 8'h00, 8'hFF, 51, 8'hFF, 1'b0};
        tbl[4] = '{1, 1'b1, 7'h7F, 8'h5A, 8'h00, 35, 8'hFF, 1'b0};
        paddr  = '{7'h0, 7'h0};
        pwdata = '{8'h0, 8'h0};
        reset = 1'b1;
        repeat (3) @(negedge pclk);
        reset = 1'b0;
        @(negedge pclk);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("reset ss%0d", g), ss[g], 1);
            chk($sformatf("reset sclk%0d", g), sclk[g], 0);
            chk($sformatf("reset mosi%0d", g), mosi[g], 0);
            chk($sformatf("reset pready%0d", g), pready[g], 0);
            chk($sformatf("reset prdata%0d", g), prdata[g], 0);
        end

        for (int i = 0; i < 5; i++)
            xfer(tbl[i].g, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].mb, tbl[i].lat, tbl[i].prd,
                 tbl[i].b2b, $sformatf("vec%0d", i));
        exp_prd[0] = 8'h3C;
        exp_prd[1] = 8'hFF;

        begin
            int ok = 1;
            psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
            repeat (10) begin
                @(negedge pclk);
                if (ss[0] !== 1'b1 || sclk[0] !== 1'b0 || pready[0] !== 1'b0) ok = 0;
            end
            psel[0] = 1'b0;
            chk("setup_only idle", ok, 1);
        end

        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 7'h05; pwdata[0] = 8'hA5;
        @(negedge pclk);
        penable[0] = 1'b1;
        repeat (60) @(negedge pclk);
        chk("midreset in_frame ss", ss[0], 0);
        #1 reset = 1'b1;
        #1;
        chk("midreset ss", ss[0], 1);
        chk("midreset sclk", sclk[0], 0);
        chk("midreset pready", pready[0], 0);
        chk("midreset prdata", prdata[0], 0);
        psel[0] = 1'b0; penable[0] = 1'b0;
        @(negedge pclk);
        reset = 1'b0;
        begin
            int seen = 0;
            repeat (20) begin
                @(negedge pclk);
                if (pready[0] !== 1'b0 || ss[0] !== 1'b1) seen++;
            end
            chk("midreset quiet", seen, 0);
        end
        exp_prd[0] = 8'h00;
        exp_prd[1] = 8'h00;
        xfer(0, 1'b1, 7'h05, 8'hA5, 8'h00, 137, exp_prd[0], 1'b0, "post_reset_wr");

        for (int i = 0; i < 16; i++) begin
            int         g   = int'($urandom_range(0, 1));
            bit         wr  = 1'($urandom);
            logic [6:0] a   = 7'($urandom);
            logic [7:0] d   = 8'($urandom);
            logic [7:0] mb  = 8'($urandom);
            int         n   = wr ? 16 : 24;
            if (!wr) exp_prd[g] = mb;
            xfer(g, wr, a, d, mb, 1 + 2 * cd(g) + 2 * cd(g) * n, exp_prd[g], 1'($urandom),
                 $sformatf("rnd%0d", i));
        end

        repeat (5) @(negedge pclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
